// File: rtl/tri_pkg.sv
// Shared definitions for the triangle host: FSM states, default sizes and the
// raster-order point key {y,x}.
package tri_pkg;

  localparam int COORD_W_DEF = 3;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND0     = 3'd1,
    SEND1     = 3'd2,
    SEND2     = 3'd3,
    WAIT_BUSY = 3'd4,
    COLLECT   = 3'd5,
    DONE      = 3'd6
  } state_e;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] x;
  } point_t;

endpackage

// File: rtl/tri_host_if.sv
// Vertex/point link between the triangle host (master) and the rasterizer
// core (slave).
interface tri_host_if import tri_pkg::*; #(
  parameter int COORD_W = COORD_W_DEF
) ();

  logic               nt;
  logic [COORD_W-1:0] xi;
  logic [COORD_W-1:0] yi;
  logic               busy;
  logic               po;
  logic [COORD_W-1:0] xo;
  logic [COORD_W-1:0] yo;

  modport master (output nt, xi, yi, input busy, po, xo, yo);
  modport slave  (input nt, xi, yi, output busy, po, xo, yo);

endinterface

// File: rtl/tri_point_collector.sv
// Accumulates reported points into an occupancy bitmap and a saturating count.
// Optional raster-order check is built when TRI_HOST_ORDER_CHECK_EN is defined.
module tri_point_collector import tri_pkg::*; #(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         en,
  input  logic [COORD_W-1:0]           xo,
  input  logic [COORD_W-1:0]           yo,
  output logic [(1<<(2*COORD_W))-1:0]  bitmap,
  output logic [2*COORD_W:0]           count,
  output logic                         order_err
);

  localparam int KEY_W = 2 * COORD_W;
  localparam int CNT_W = KEY_W + 1;
  localparam int BM_W  = 1 << KEY_W;

  logic [KEY_W-1:0] key_s;
  logic [BM_W-1:0]  bitmap_q, bitmap_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign key_s  = {yo, xo};
  assign bitmap = bitmap_q;
  assign count  = count_q;

  always_comb begin
    bitmap_d = bitmap_q;
    count_d  = count_q;
    if (clr) begin
      bitmap_d = '0;
      count_d  = '0;
    end else if (en) begin
      bitmap_d[key_s] = 1'b1;
      // duplicates still count; the counter sticks at all-ones
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end else begin
      bitmap_d = bitmap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bitmap_q <= '0;
      count_q  <= '0;
    end else begin
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
    end
  end

`ifdef TRI_HOST_ORDER_CHECK_EN
  logic [KEY_W-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;

  assign order_err = en && have_prev_q && (key_s <= prev_q);

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (clr) begin
      prev_d      = '0;
      have_prev_d = 1'b0;
    end else if (en) begin
      prev_d      = key_s;
      have_prev_d = 1'b1;
    end else begin
      have_prev_d = have_prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: rtl/tri_host.sv
// Triangle host: latches three vertices on start, serialises them to the
// rasterizer, then collects points until busy falls. Honours TRI_HOST_ORDER_CHECK_EN.
module tri_host import tri_pkg::*; #(
  parameter int COORD_W = COORD_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [COORD_W-1:0]           v0x,
  input  logic [COORD_W-1:0]           v0y,
  input  logic [COORD_W-1:0]           v1x,
  input  logic [COORD_W-1:0]           v1y,
  input  logic [COORD_W-1:0]           v2x,
  input  logic [COORD_W-1:0]           v2y,
  tri_host_if.master                   ras,
  output logic                         ready,
  output logic                         done,
  output logic                         err,
  output logic [(1<<(2*COORD_W))-1:0]  bitmap,
  output logic [2*COORD_W:0]           count
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [2:0][COORD_W-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic                      nt_q, nt_d;
  logic [COORD_W-1:0]        xi_q, xi_d, yi_q, yi_d;
  logic                      ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic                      clr_s, collect_en_s, order_err_s;

  assign collect_en_s = ras.po && ((state_q == COLLECT) ||
                                   ((state_q == WAIT_BUSY) && ras.busy));

  // Outputs are computed for the next state so the registered wire lines up with state_q
  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    timer_d = timer_q;
    nt_d    = 1'b0;
    xi_d    = '0;
    yi_d    = '0;
    done_d  = 1'b0;
    err_d   = err_q | order_err_s;
    clr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          vx_d    = {v2x, v1x, v0x};
          vy_d    = {v2y, v1y, v0y};
          clr_s   = 1'b1;
          err_d   = 1'b0;
          nt_d    = 1'b1;
          xi_d    = v0x;
          yi_d    = v0y;
          state_d = SEND0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND0: begin
        xi_d    = vx_q[1];
        yi_d    = vy_q[1];
        state_d = SEND1;
      end
      SEND1: begin
        xi_d    = vx_q[2];
        yi_d    = vy_q[2];
        state_d = SEND2;
      end
      SEND2: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (ras.busy) begin
          state_d = COLLECT;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      COLLECT: begin
        if (!ras.busy) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = COLLECT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      vx_q    <= '0;
      vy_q    <= '0;
      timer_q <= '0;
      nt_q    <= 1'b0;
      xi_q    <= '0;
      yi_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      timer_q <= timer_d;
      nt_q    <= nt_d;
      xi_q    <= xi_d;
      yi_q    <= yi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  tri_point_collector #(.COORD_W(COORD_W)) u_collector (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr_s),
    .en        (collect_en_s),
    .xo        (ras.xo),
    .yo        (ras.yo),
    .bitmap    (bitmap),
    .count     (count),
    .order_err (order_err_s)
  );

  assign ras.nt = nt_q;
  assign ras.xi = xi_q;
  assign ras.yi = yi_q;
  assign ready  = ready_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_tri_host.sv
// Scoreboard bench for tri_host: expected wire vertices and collection results
// are queued as stimulus is driven and compared when the DUT produces them.
module tb_tri_host;
  import tri_pkg::*;

  localparam int CW = 3;
  localparam int TO = 16;
  localparam int BW = 1 << (2*CW);

  logic          clk = 1'b0;
  logic          reset, start;
  logic [CW-1:0] v0x, v0y, v1x, v1y, v2x, v2y;
  logic          ready, done, err;
  logic [BW-1:0] bitmap;
  logic [2*CW:0] count;

  tri_host_if #(.COORD_W(CW)) ras ();

  tri_host #(.COORD_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .ras(ras), .ready(ready), .done(done), .err(err),
    .bitmap(bitmap), .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [2*CW:0]        vq[$];     // {nt, xi, yi}
  logic [BW+2*CW+1:0]   exp_q[$];  // {bitmap, count, err}
  logic [2*CW-1:0]      pts_q[$];  // point keys {y,x} to report

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_tri(input logic [CW-1:0] ax, ay, bx, by, cx, cy);
    logic [2*CW:0] e;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL ready_before_start: got %b expected 1", ready); end
    v0x = ax; v0y = ay; v1x = bx; v1y = by; v2x = cx; v2y = cy;
    start = 1'b1;
    vq.push_back({1'b1, ax, ay});
    vq.push_back({1'b0, bx, by});
    vq.push_back({1'b0, cx, cy});
    @(negedge clk);
    start = 1'b0;
    v0x = CW'($urandom); v0y = CW'($urandom); v1x = CW'($urandom);
    v1y = CW'($urandom); v2x = CW'($urandom); v2y = CW'($urandom);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL ready_fall: got %b expected 0", ready); end
    while (vq.size() > 0) begin
      e = vq.pop_front();
      tests++;
      if ({ras.nt, ras.xi, ras.yi} !== e) begin
        fails++; $display("FAIL send_vertex: got %h expected %h", {ras.nt, ras.xi, ras.yi}, e);
      end
      @(negedge clk);
    end
    tests++;
    if ({ras.nt, ras.xi, ras.yi} !== '0) begin
      fails++; $display("FAIL wire_idle: got %h expected 0", {ras.nt, ras.xi, ras.yi});
    end
  endtask

  // Streams pts_q after `gap` idle WAIT_BUSY cycles; busy rises with the first point.
  task automatic run_collect(input int gap, input bit fall_with_last);
    logic [BW-1:0]     eb;
    logic [2*CW:0]     ec;
    logic              ee;
    logic [2*CW-1:0]   k;
    logic [2*CW-1:0]   prev;
    bit                have;
    point_t            p;
    logic [BW+2*CW+1:0] e;
    int                lat;
    int                exp_lat;
    eb = '0; ec = '0; ee = 1'b0; prev = '0; have = 1'b0;
    repeat (gap) @(negedge clk);
    ras.busy = 1'b1;
    if (pts_q.size() == 0) @(negedge clk);
    while (pts_q.size() > 0) begin
      k = pts_q.pop_front();
      p = point_t'(k);
      ras.xo = p.x; ras.yo = p.y; ras.po = 1'b1;
      if (pts_q.size() == 0 && fall_with_last) ras.busy = 1'b0;
      eb[k] = 1'b1;
      if (ec != {(2*CW+1){1'b1}}) ec = ec + 1'b1;
`ifdef TRI_HOST_ORDER_CHECK_EN
      if (have && k <= prev) ee = 1'b1;
      prev = k; have = 1'b1;
`endif
      @(negedge clk);
    end
    ras.po = 1'b0;
    ras.busy = 1'b0;
    exp_q.push_back({eb, ec, ee});
    exp_lat = fall_with_last ? 0 : 1;
    lat = 0;
    while (done !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
    tests++; if (lat !== exp_lat) begin fails++; $display("FAIL done_latency: got %0d expected %0d", lat, exp_lat); end
    e = exp_q.pop_front();
    tests++;
    if ({bitmap, count, err} !== e) begin
      fails++; $display("FAIL collect_result: got %h/%0d/%b expected %h/%0d/%b",
                        bitmap, count, err, e[BW+2*CW+1:2*CW+2], e[2*CW+1:1], e[0]);
    end
    @(negedge clk);
    tests++; if ({done, ready} !== 2'b01) begin fails++; $display("FAIL done_one_cycle: got done=%b ready=%b expected 0/1", done, ready); end
  endtask

  task automatic test_reset();
    tests++;
    if ({ready, ras.nt, ras.xi, ras.yi, done, err, bitmap, count} !== {1'b1, {(2*CW+3+BW+2*CW+1){1'b0}}}) begin
      fails++; $display("FAIL reset_state: got r%b nt%b x%0d y%0d d%b e%b bm%h c%0d",
                        ready, ras.nt, ras.xi, ras.yi, done, err, bitmap, count);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++; if ({ready, ras.nt} !== 2'b10) begin fails++; $display("FAIL idle_after_reset: got %b expected 10", {ready, ras.nt}); end
  endtask

  task automatic test_collect();
    send_tri(3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd3);
    pts_q.push_back(6'd0);   // (0,0)
    pts_q.push_back(6'd1);   // (1,0)
    pts_q.push_back(6'd8);   // (0,1)
    run_collect(1, 1'b0);
    tests++; if (bitmap !== 64'h0000_0000_0000_0103) begin fails++; $display("FAIL collect_bitmap: got %h expected 103", bitmap); end
    tests++; if (count !== 7'd3 || err !== 1'b0) begin fails++; $display("FAIL collect_count: got %0d/%b expected 3/0", count, err); end
  endtask

  task automatic test_fall_with_po();
    send_tri(3'd5, 3'd1, 3'd2, 3'd6, 3'd7, 3'd7);
    pts_q.push_back(6'd10); pts_q.push_back(6'd20); pts_q.push_back(6'd20); pts_q.push_back(6'd63);
    run_collect(0, 1'b1);
  endtask

  task automatic test_timeout();
    int n;
    bit saw_done;
    n = 0; saw_done = 1'b0;
    send_tri(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6);
    while (err !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    tests++; if (n !== TO) begin fails++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TO); end
    tests++; if (saw_done || ready !== 1'b1) begin fails++; $display("FAIL timeout_idle: got done_seen=%b ready=%b expected 0/1", saw_done, ready); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b expected 0", err); end
    repeat (3) @(negedge clk);
    run_collect(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen;
    send_tri(3'd4, 3'd4, 3'd1, 3'd1, 3'd6, 3'd2);
    ras.busy = 1'b1; ras.po = 1'b1; ras.xo = 3'd3; ras.yo = 3'd0;
    @(negedge clk);
    ras.xo = 3'd4;
    @(negedge clk);
    ras.po = 1'b0;
    tests++; if (count !== 7'd2) begin fails++; $display("FAIL count_before_reset: got %0d expected 2", count); end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({ready, bitmap, count, ras.nt, done} !== {1'b1, {(BW+2*CW+3){1'b0}}}) begin
      fails++; $display("FAIL reset_mid: got r%b bm%h c%0d nt%b d%b", ready, bitmap, count, ras.nt, done);
    end
    reset = 1'b1; ras.busy = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (done === 1'b1) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL reset_no_done: got %0d expected 0", seen); end
  endtask

  task automatic test_ignored_start();
    send_tri(3'd2, 3'd1, 3'd4, 3'd1, 3'd2, 3'd5);
    v0x = 3'd7; v0y = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if ({ras.nt, ras.xi, ras.yi, ready} !== '0) begin fails++; $display("FAIL start_in_wait: got %h expected 0", {ras.nt, ras.xi, ras.yi, ready}); end
    ras.busy = 1'b1; ras.po = 1'b1; ras.xo = 3'd1; ras.yo = 3'd1;
    @(negedge clk);
    ras.po = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if ({ras.nt, ras.xi, ras.yi, ready} !== '0) begin fails++; $display("FAIL start_in_collect: got %h expected 0", {ras.nt, ras.xi, ras.yi, ready}); end
    ras.busy = 1'b0;
    @(negedge clk);
    tests++; if ({done, count, bitmap} !== {1'b1, 7'd1, 64'h200}) begin fails++; $display("FAIL ignored_done: got d%b c%0d bm%h expected 1/1/200", done, count, bitmap); end
    repeat (2) @(negedge clk);
    tests++; if ({ras.nt, ready} !== 2'b01) begin fails++; $display("FAIL start_not_queued: got %b expected 01", {ras.nt, ready}); end
  endtask

  task automatic test_order();
    logic exp_err;
`ifdef TRI_HOST_ORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send_tri(3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1);
    pts_q.push_back(6'd1);   // (1,0)
    pts_q.push_back(6'd0);   // (0,0)
    run_collect(2, 1'b0);
    tests++; if ({err, count} !== {exp_err, 7'd2}) begin fails++; $display("FAIL order_err: got %b/%0d expected %b/2", err, count, exp_err); end
  endtask

  task automatic test_saturate();
    send_tri(3'd7, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7);
    for (int i = 0; i < 130; i++) pts_q.push_back(6'(i));
    run_collect(0, 1'b0);
    tests++; if (count !== 7'h7f) begin fails++; $display("FAIL count_saturate: got %0d expected 127", count); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
    ras.busy = 1'b0; ras.po = 1'b0; ras.xo = '0; ras.yo = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_collect();
    test_fall_with_po();
    test_timeout();
    test_reset_mid();
    test_ignored_start();
    test_order();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tri_host.md
Name: tri_host

Overview:
- Initiator end of the triangle rasterizer vertex/point interface.
- Latches three vertices on `start` and serialises them to the rasterizer on `nt`/`xi`/`yi`.
- Then collects every point reported on `po`/`xo`/`yo` into an occupancy bitmap plus point count, and flags done or error.
- Sits between the test/control logic and the rasterizer core.

Parameters:
- COORD_W, 3, coordinate width in bits; the grid is 2^COORD_W x 2^COORD_W.
- TIMEOUT, 16, maximum cycles to wait for `busy` to rise after the last vertex is sent.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to send a triangle; ignored unless IDLE.
- v0x,v0y,v1x,v1y,v2x,v2y  input  COORD_W each  vertex coordinates, sampled on the accepted `start`.
- nt  output  1  new-triangle strobe to the rasterizer; high only in the cycle vertex 0 is driven.
- xi  output  COORD_W  vertex x to the rasterizer.
- yi  output  COORD_W  vertex y to the rasterizer.
- busy  input  1  rasterizer is emitting points.
- po  input  1  point valid.
- xo  input  COORD_W  point x.
- yo  input  COORD_W  point y.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse when collection ends normally.
- err  output  1  sticky error flag; cleared by the next accepted `start`.
- bitmap  output  2^(2*COORD_W)  bit index is `{yo,xo}`; set for each reported point.
- count  output  2*COORD_W+1  number of `po` pulses accepted.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; nt=0; xi=0; yi=0; done=0; err=0; bitmap=0; count=0; ready=1.
  - Reset mid-operation aborts immediately; no `done` pulse is produced.
- Output registration: all outputs are registered, and `xi`/`yi` are 0 outside the SEND states.
- IDLE:
  - On `start` (with ready=1): latch all six vertex inputs, clear bitmap/count/err, go to SEND0.
- SEND0: nt=1, xi=v0x, yi=v0y; go to SEND1.
- SEND1: nt=0, xi=v1x, yi=v1y; go to SEND2.
- SEND2: xi=v2x, yi=v2y; go to WAIT_BUSY with the timer at 0.
- Vertex order on the wire is exactly v0, v1, v2 on three consecutive cycles, `nt` coinciding with v0. No reordering or validation of triangle shape.
- WAIT_BUSY:
  - Timer increments each cycle.
  - If busy==1, go to COLLECT; a `po` pulse arriving in this same cycle is also accepted.
  - If the timer reaches TIMEOUT-1 with busy still 0: err=1, go to IDLE with no `done`.
- COLLECT:
  - Each cycle with po==1: set `bitmap[{yo,xo}]`; count+=1, saturating at all-ones.
  - A duplicate point re-sets the same bit but still increments count.
  - When busy==0: go to DONE. A `po` in that same cycle is still accepted.
- DONE: done=1 for exactly one cycle, then IDLE. `bitmap`/`count` hold until the next accepted `start`.
- Ignored events:
  - `start` outside IDLE is ignored; it is not queued.
  - `po` while in IDLE/SEND is ignored.
- Latency: `start` to `nt` is 1 cycle; `busy` falling to `done` is 1 cycle.

Optional Feature:
- Macro: TRI_HOST_ORDER_CHECK_EN.
- Defined: in COLLECT, each accepted point must be strictly greater than the previous one in raster order (key `{yo,xo}`, y-major). A violation sets err=1; collection continues and `done` still pulses.
- Undefined: no order register and no check; err is set only by timeout.

Decomposition:
- Package tri_pkg:
  - state enum (IDLE, SEND0, SEND1, SEND2, WAIT_BUSY, COLLECT, DONE);
  - COORD_W default;
  - a point typedef `{y,x}`.
- Sub-module tri_point_collector: bitmap, saturating count and the optional order check, enabled by the FSM's collect qualifier. The FSM and vertex serialiser stay in tri_host.

Test Plan:
- Send: start with v0=(0,0), v1=(3,0), v2=(0,3) -> ready falls; nt=1 with xi/yi=0/0, then 3/0 and 0/3 on the next two cycles; nt=0 after the first cycle.
- Collect: model asserts busy 2 cycles after SEND2 and reports (0,0),(1,0),(0,1) -> bitmap bits 0, 1, 8 set; count=3; done pulses 1 cycle after busy falls; err=0.
- Timeout: busy held 0 after SEND2 -> err=1 at cycle TIMEOUT of WAIT_BUSY; no done; ready=1; a following start clears err.
- Reset: reset low during COLLECT after 2 points -> next cycle state IDLE, bitmap=0, count=0, nt=0, no done.
- Ignored start: start pulsed during WAIT_BUSY and COLLECT -> no effect on nt, xi, yi or the latched vertices.
- Order check (TRI_HOST_ORDER_CHECK_EN): points (1,0) then (0,0) -> err=1, done still pulses, count=2. With the macro undefined -> err=0.
